// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RX fetch path.
// Register addresses come from the ethernet address map when it is included first.
`ifndef ETHERNET_RX_DATA
`define ETHERNET_RX_DATA 32'h0000_0020
`endif
`ifndef ETHERNET_RX_DATA_COUNT
`define ETHERNET_RX_DATA_COUNT 32'h0000_0024
`endif
`ifndef ETHERNET_RX_PROTOCOL_TYPE
`define ETHERNET_RX_PROTOCOL_TYPE 32'h0000_0028
`endif

package eth_pkg;

    localparam int          ETH_MAX_FRAME_BYTES        = 1522;
    localparam logic [31:0] ETH_RX_DATA_ADDR           = `ETHERNET_RX_DATA;
    localparam logic [31:0] ETH_RX_DATA_COUNT_ADDR     = `ETHERNET_RX_DATA_COUNT;
    localparam logic [31:0] ETH_RX_PROTOCOL_TYPE_ADDR  = `ETHERNET_RX_PROTOCOL_TYPE;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AR_CNT   = 3'd1,
        R_CNT    = 3'd2,
        AR_PROTO = 3'd3,
        R_PROTO  = 3'd4,
        AR_DATA  = 3'd5,
        R_DATA   = 3'd6,
        DRAIN    = 3'd7
    } eth_rx_fetch_state_t;

    // 17-bit result so a 16'hFFFF byte count cannot wrap.
    function automatic logic [16:0] eth_expected_beats(input logic [15:0] len);
        return ({1'b0, len} + 17'd3) >> 2;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle between the RX fetch master and the ethernet register slave.
// Only the read channels carry traffic; the write side is tied idle by the master.
interface AXI_LITE;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic        awvalid;
    logic        wvalid;
    logic        wlast;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awvalid, wvalid, wlast, bready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, rready, awvalid, wvalid, wlast, bready,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/eth_sat_counter.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module eth_sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/eth_rx_fetch.sv
// AXI read master that drains one received frame per rx_ready_int rising edge
// (count, protocol, data burst) and forwards the data beats as a word stream.
module eth_rx_fetch
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                clk_100_mhz,
    input  logic                rst_n,
    AXI_LITE.master             axi,
    input  logic                rx_ready_int,
    input  logic                enable,
    output logic [31:0]         m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                frame_start,
    output logic [15:0]         frame_len,
    output logic [15:0]         frame_proto,
    output logic [15:0]         frames_ok,
    output logic [15:0]         frames_err,
    output logic                busy,
    output eth_rx_fetch_state_t dbg_state
);

    // Handshakes: a transfer happens only at a clock edge where valid and ready
    // are both high; valid never waits on ready, and payload is stable while valid.

    localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);

    eth_rx_fetch_state_t state, state_next;

    logic          rx_prev;
    logic          edge_q;
    logic [TW-1:0] timer;
    logic          discard;
    logic [16:0]   beat_cnt;
    logic          data_started;

    logic          timeout;
    logic          ar_hs;
    logic          r_hs;
    logic          len_capture;
    logic          proto_capture;
    logic [15:0]   new_len;
    logic          len_too_long;
    logic          beat;
    logic          last_beat;
    logic          beat_mismatch;
    logic          ok_inc;
    logic          err_inc;

    assign timeout       = (state != IDLE) && (timer == TO_LAST);
    assign ar_hs         = axi.arvalid & axi.arready;
    assign r_hs          = axi.rvalid & axi.rready;
    assign new_len       = axi.rdata[15:0];
    assign len_too_long  = new_len > MAX_LEN;
    assign len_capture   = (state == R_CNT) && r_hs;
    assign proto_capture = (state == R_PROTO) && r_hs;
    assign beat          = (state == R_DATA) && r_hs;
    assign last_beat     = beat && axi.rlast;
    assign beat_mismatch = (beat_cnt + 17'd1) != eth_expected_beats(frame_len);

    // rready is forced low on timeout, so a timeout can never coincide with a
    // completed frame; error wins by construction.
    assign ok_inc  = last_beat && !discard && !beat_mismatch && !timeout;
    assign err_inc = timeout
                   || (len_capture && (new_len == 16'd0))
                   || (last_beat && (discard || beat_mismatch));

    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (edge_q && enable) state_next = AR_CNT;
            AR_CNT:   if (ar_hs) state_next = R_CNT;
            R_CNT: begin
                if (r_hs) begin
                    if (new_len == 16'd0)  state_next = IDLE;
                    else if (len_too_long) state_next = AR_DATA;
                    else                   state_next = AR_PROTO;
                end
            end
            AR_PROTO: if (ar_hs) state_next = R_PROTO;
            R_PROTO:  if (r_hs) state_next = AR_DATA;
            AR_DATA:  if (ar_hs) state_next = R_DATA;
            R_DATA:   if (last_beat) state_next = DRAIN;
            DRAIN:    state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (timeout) state_next = IDLE;
    end

    always_comb begin
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.rready  = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = '0;
        frame_start = 1'b0;
        case (state)
            AR_CNT: begin
                axi.arvalid = ~timeout;
                axi.araddr  = ETH_RX_DATA_COUNT_ADDR;
            end
            AR_PROTO: begin
                axi.arvalid = ~timeout;
                axi.araddr  = ETH_RX_PROTOCOL_TYPE_ADDR;
            end
            AR_DATA: begin
                axi.arvalid = ~timeout;
                axi.araddr  = ETH_RX_DATA_ADDR;
            end
            R_CNT, R_PROTO: axi.rready = ~timeout;
            R_DATA: begin
                if (discard) begin
                    axi.rready = ~timeout;
                end else begin
                    // No local buffering: the consumer back-pressures the slave directly.
                    axi.rready  = m_ready & ~timeout;
                    m_valid     = axi.rvalid & ~timeout;
                    m_last      = axi.rvalid & axi.rlast & ~timeout;
                    m_data      = axi.rdata;
                    frame_start = ~data_started;
                end
            end
            default: ;
        endcase
    end

    assign axi.awvalid = 1'b0;
    assign axi.wvalid  = 1'b0;
    assign axi.wlast   = 1'b0;
    assign axi.bready  = 1'b0;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    // rx_prev resets high so an interrupt level held through reset is not an edge.
    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev      <= 1'b1;
            edge_q       <= 1'b0;
            timer        <= '0;
            frame_len    <= '0;
            frame_proto  <= '0;
            discard      <= 1'b0;
            beat_cnt     <= '0;
            data_started <= 1'b0;
        end else begin
            rx_prev <= rx_ready_int;
            edge_q  <= rx_ready_int & ~rx_prev;
            if ((state != state_next) || ar_hs || r_hs) begin
                timer <= '0;
            end else if (state != IDLE) begin
                timer <= timer + TW'(1);
            end
            if (len_capture) begin
                frame_len <= new_len;
                discard   <= len_too_long;
            end
            if (proto_capture) frame_proto <= axi.rdata[15:0];
            if (state == AR_DATA) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 17'd1;
            end
            data_started <= (state == R_DATA);
        end
    end

    eth_sat_counter u_ok_cnt (
        .clk   (clk_100_mhz),
        .rst_n (rst_n),
        .inc   (ok_inc),
        .count (frames_ok)
    );

    eth_sat_counter u_err_cnt (
        .clk   (clk_100_mhz),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (frames_err)
    );

endmodule

// File: tb/tb_eth_rx_fetch.sv
// Randomised frame-level bench for eth_rx_fetch with a behavioural AXI slave,
// a frame outcome model and a word scoreboard.
module tb_eth_rx_fetch;
    import eth_pkg::*;

    localparam int TO   = 16;
    localparam int MAXB = ETH_MAX_FRAME_BYTES;

    logic                clk_100_mhz = 1'b0;
    logic                rst_n       = 1'b0;
    logic                rx_ready_int = 1'b0;
    logic                enable      = 1'b0;
    logic                m_ready     = 1'b0;
    logic [31:0]         m_data;
    logic                m_valid;
    logic                m_last;
    logic                frame_start;
    logic [15:0]         frame_len;
    logic [15:0]         frame_proto;
    logic [15:0]         frames_ok;
    logic [15:0]         frames_err;
    logic                busy;
    eth_rx_fetch_state_t dbg_state;

    AXI_LITE axi_bus ();

    eth_rx_fetch #(
        .MAX_FRAME_BYTES (MAXB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk_100_mhz  (clk_100_mhz),
        .rst_n        (rst_n),
        .axi          (axi_bus),
        .rx_ready_int (rx_ready_int),
        .enable       (enable),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .frame_start  (frame_start),
        .frame_len    (frame_len),
        .frame_proto  (frame_proto),
        .frames_ok    (frames_ok),
        .frames_err   (frames_err),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk_100_mhz = ~clk_100_mhz;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [32:0] exp_q[$];
    int          m_ok    = 0;
    int          m_err   = 0;
    logic [15:0] m_len   = 16'd0;
    logic [15:0] m_proto = 16'd0;

    function automatic int exp_beats(input int len);
        return len / 4 + (((len % 4) != 0) ? 1 : 0);
    endfunction

    // consumer side: drives m_ready, scores accepted words
    int   mode = 0;
    int   low_run = 0;
    logic tog = 1'b0;
    int   mirror_bad = 0;
    int   disc_valid = 0;
    int   fs_cnt = 0;
    int   n_extra = 0;
    bit   in_discard = 1'b0;

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_100_mhz);
            case (mode)
                0: m_ready = 1'b1;
                1: begin tog = ~tog; m_ready = tog; end
                default: m_ready = (low_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            low_run = m_ready ? 0 : low_run + 1;
            #2;
            if (frame_start) fs_cnt++;
            if (m_valid) begin
                if (axi_bus.rready !== m_ready) mirror_bad++;
                if (in_discard) disc_valid++;
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_extra++;
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("word", {31'd0, m_last, m_data}, {31'd0, e});
                    end
                end
            end
        end
    end

    // slave driver tasks: start and end on a negedge drive point
    task automatic ar_serve(input logic [31:0] exp_addr, input string tag);
        int n;
        int dly;
        n   = 0;
        dly = $urandom_range(0, 3);
        #2;
        while (!axi_bus.arvalid && n < 40) begin
            @(negedge clk_100_mhz);
            #2;
            n++;
        end
        check_eq({tag, "_seen"}, 64'(axi_bus.arvalid), 64'd1);
        repeat (dly) @(negedge clk_100_mhz);
        if (dly > 0) #2;
        check_eq({tag, "_hold"}, 64'(axi_bus.arvalid), 64'd1);
        check_eq({tag, "_addr"}, 64'(axi_bus.araddr), 64'(exp_addr));
        axi_bus.arready = 1'b1;
        @(negedge clk_100_mhz);
        axi_bus.arready = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] data, input bit last);
        int n;
        int gap;
        n = 0;
        gap = $urandom_range(0, 1);
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = data;
        axi_bus.rlast  = last;
        #2;
        while (!axi_bus.rready && n < 40) begin
            @(negedge clk_100_mhz);
            #2;
            n++;
        end
        check_eq("rready_seen", 64'(axi_bus.rready), 64'd1);
        @(negedge clk_100_mhz);
        axi_bus.rvalid = 1'b0;
        axi_bus.rlast  = 1'b0;
        axi_bus.rdata  = $urandom;
        repeat (gap) @(negedge clk_100_mhz);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        int ar_seen;
        n = 0;
        ar_seen = 0;
        #2;
        while (busy && n < bound) begin
            if (axi_bus.arvalid) ar_seen++;
            @(negedge clk_100_mhz);
            #2;
            n++;
        end
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_no_extra_ar"}, 64'(ar_seen), 64'd0);
        @(negedge clk_100_mhz);
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_frames_ok"},  64'(frames_ok),  64'(m_ok));
        check_eq({tag, "_frames_err"}, 64'(frames_err), 64'(m_err));
        check_eq({tag, "_frame_len"},  64'(frame_len),  64'(m_len));
        check_eq({tag, "_frame_proto"}, 64'(frame_proto), 64'(m_proto));
    endtask

    task automatic run_frame(input string tag, input logic [15:0] len, input logic [15:0] proto,
                             input int nbeats, input int rmode);
        logic [31:0] w;
        bit          normal;
        normal     = (len != 16'd0) && (int'(len) <= MAXB);
        mode       = rmode;
        fs_cnt     = 0;
        mirror_bad = 0;
        disc_valid = 0;
        n_extra    = 0;
        in_discard = int'(len) > MAXB;
        rx_ready_int = 1'b1;
        ar_serve(ETH_RX_DATA_COUNT_ADDR, {tag, "_ar_cnt"});
        r_beat({16'($urandom), len}, 1'b0);
        m_len = len;
        if (len == 16'd0) begin
            m_err++;
        end else begin
            if (normal) begin
                ar_serve(ETH_RX_PROTOCOL_TYPE_ADDR, {tag, "_ar_proto"});
                r_beat({16'($urandom), proto}, 1'b0);
                m_proto = proto;
            end
            ar_serve(ETH_RX_DATA_ADDR, {tag, "_ar_data"});
            for (int i = 0; i < nbeats; i++) begin
                w = $urandom;
                if (normal) exp_q.push_back({i == nbeats - 1, w});
                r_beat(w, i == nbeats - 1);
            end
            if (!normal || nbeats != exp_beats(int'(len))) m_err++;
            else m_ok++;
        end
        wait_idle(tag, 4);
        rx_ready_int = 1'b0;
        in_discard   = 1'b0;
        @(negedge clk_100_mhz);
        check_counters(tag);
        check_eq({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_extra_words"}, 64'(n_extra), 64'd0);
        check_eq({tag, "_frame_start"}, 64'(fs_cnt), (normal && len != 0) ? 64'd1 : 64'd0);
        check_eq({tag, "_rready_mirror"}, 64'(mirror_bad), 64'd0);
        check_eq({tag, "_discard_mvalid"}, 64'(disc_valid), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int av;
        logic [31:0] w;
        logic [15:0] rl;
        axi_bus.arready = 1'b0;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rdata   = '0;
        axi_bus.rlast   = 1'b0;

        // reset state
        repeat (3) @(negedge clk_100_mhz);
        #2;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_state", 64'(dbg_state), 64'(IDLE));
        check_eq("reset_outs", {26'd0, m_valid, m_last, frame_start, axi_bus.arvalid,
                 axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid, axi_bus.wlast, m_data}, 64'd0);
        check_eq("reset_addr", 64'(axi_bus.araddr), 64'd0);
        check_eq("reset_cnts", {frames_ok, frames_err, frame_len, frame_proto}, 64'd0);
        @(negedge clk_100_mhz);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk_100_mhz);

        // directed frames
        run_frame("f64",   16'd64,   16'h0800, 16, 0);
        run_frame("f61",   16'd61,   16'h0800, 16, 1);
        run_frame("f2000", 16'd2000, 16'h86DD, 500, 0);
        run_frame("f0",    16'd0,    16'h0000, 0, 0);
        run_frame("fmis",  16'd64,   16'h0806, 15, 2);
        run_frame("f1522", 16'd1522, 16'h0800, 381, 0);

        // enable low: edge must not start a fetch
        enable = 1'b0;
        rx_ready_int = 1'b1;
        repeat (4) @(negedge clk_100_mhz);
        #2;
        check_eq("disabled_busy", 64'(busy), 64'd0);
        @(negedge clk_100_mhz);
        rx_ready_int = 1'b0;
        enable = 1'b1;
        @(negedge clk_100_mhz);

        // latency and AR timeout with a silent slave
        rx_ready_int = 1'b1;
        #2;
        check_eq("lat0_arvalid", 64'(axi_bus.arvalid), 64'd0);
        @(negedge clk_100_mhz);
        #2;
        check_eq("lat1_arvalid", 64'(axi_bus.arvalid), 64'd0);
        @(negedge clk_100_mhz);
        #2;
        check_eq("lat2_arvalid", 64'(axi_bus.arvalid), 64'd1);
        n  = 1;
        av = 1;
        while (busy && n < 100) begin
            @(negedge clk_100_mhz);
            #2;
            if (busy) n++;
            if (axi_bus.arvalid) av++;
        end
        m_err++;
        check_eq("to_busy_cycles", 64'(n), 64'(TO));
        check_eq("to_arvalid_cycles", 64'(av), 64'(TO - 1));
        check_eq("to_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk_100_mhz);
        rx_ready_int = 1'b0;
        check_counters("to");
        @(negedge clk_100_mhz);
        run_frame("after_to", 16'd40, 16'h0800, 10, 2);

        // reset during beat 5 of 16
        mode = 0;
        rx_ready_int = 1'b1;
        ar_serve(ETH_RX_DATA_COUNT_ADDR, "rst_ar_cnt");
        r_beat({16'($urandom), 16'd64}, 1'b0);
        ar_serve(ETH_RX_PROTOCOL_TYPE_ADDR, "rst_ar_proto");
        r_beat({16'($urandom), 16'h0800}, 1'b0);
        ar_serve(ETH_RX_DATA_ADDR, "rst_ar_data");
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            exp_q.push_back({1'b0, w});
            r_beat(w, 1'b0);
        end
        w = $urandom;
        exp_q.push_back({1'b0, w});
        axi_bus.rvalid = 1'b1;
        axi_bus.rdata  = w;
        axi_bus.rlast  = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_outs", {27'd0, m_valid, m_last, frame_start, axi_bus.arvalid,
                 axi_bus.rready, m_data}, 64'd0);
        check_eq("rst_addr", 64'(axi_bus.araddr), 64'd0);
        check_eq("rst_cnts", {frames_ok, frames_err, frame_len, frame_proto}, 64'd0);
        check_eq("rst_words_left", 64'(exp_q.size()), 64'd0);
        axi_bus.rvalid = 1'b0;
        @(negedge clk_100_mhz);
        rst_n = 1'b1;
        m_ok = 0; m_err = 0; m_len = 16'd0; m_proto = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100_mhz);
            #2;
            check_eq("rst_no_fetch", {62'd0, busy, axi_bus.arvalid}, 64'd0);
        end
        @(negedge clk_100_mhz);
        rx_ready_int = 1'b0;
        @(negedge clk_100_mhz);
        run_frame("after_rst", 16'd64, 16'h0800, 16, 0);

        // randomised frames
        for (int k = 0; k < 8; k++) begin
            rl = 16'($urandom_range(1, 160));
            run_frame("rand", rl, 16'($urandom), exp_beats(int'(rl)), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_rx_fetch.md
# eth_rx_fetch

AXI read master that drains received Ethernet frames from the AXI_ethernet register slave and presents them as a 32-bit valid/ready word stream. It sits between the ethernet peripheral's AXI slave port and a downstream frame consumer (packet parser or DMA).
- On each rising edge of the receive interrupt it reads the byte count, then the protocol type, then bursts the RX data register until the last beat.
- It keeps good/bad frame statistics and recovers from a stalled slave via a handshake timeout.

## Interface
- MAX_FRAME_BYTES, 1522: largest accepted frame; longer frames are drained and discarded.
- TIMEOUT_CYCLES, 1024: idle cycles allowed per handshake before abort.
- clk_100_mhz  in  1  single clock; also drives the AXI interface clock.
- rst_n  in  1  asynchronous, active-low reset.
- axi  AXI_LITE.master  —  AR/R channels used; AW/W/B held idle (awvalid=0, wvalid=0, wlast=0).
- rx_ready_int  in  1  frame-available interrupt from the ethernet slave.
- enable  in  1  allows new fetches; clearing it does not abort a fetch in progress.
- m_data  out  32  frame word, byte 0 in bits [7:0].
- m_valid  out  1  word valid.
- m_last  out  1  final word of the frame.
- m_ready  in  1  consumer accepts word.
- frame_start  out  1  one-cycle pulse when the data burst begins.
- frame_len  out  16  byte count of the current frame.
- frame_proto  out  16  protocol type of the current frame.
- frames_ok  out  16  saturating good-frame count.
- frames_err  out  16  saturating error count (length, mismatch, timeout).
- busy  out  1  high whenever the FSM is outside IDLE.

## Operation
- States: IDLE, AR_CNT, R_CNT, AR_PROTO, R_PROTO, AR_DATA, R_DATA, DRAIN.
- IDLE → AR_CNT on an rx_ready_int rising edge (registered previous value) while enable=1. An edge arriving while busy is ignored.
- AR_* states drive araddr and arvalid=1 until arvalid&arready is sampled. In the following cycle arvalid=0 and the FSM moves to the matching R_* state.
  - AR_CNT uses `ETHERNET_RX_DATA_COUNT.
  - AR_PROTO uses `ETHERNET_RX_PROTOCOL_TYPE.
  - AR_DATA uses `ETHERNET_RX_DATA.
- R_CNT / R_PROTO hold rready=1 and capture rdata[15:0] on rvalid into frame_len / frame_proto.
  - From R_CNT:
    - If len=0, increment frames_err and go to IDLE.
    - If len>MAX_FRAME_BYTES, go to AR_DATA flagged as discard.
    - Otherwise go to AR_PROTO.
- Expected beats = (len+3)>>2, computed in 17 bits so there is no overflow.
- R_DATA, normal frame:
  - m_valid=rvalid, m_data=rdata, rready=m_ready.
  - m_last=rlast.
  - frame_start pulses on the first R_DATA cycle.
  - Beats are counted on rvalid&rready.
- R_DATA, discard frame: rready=1 and m_valid=0.
- On the beat with rlast:
  - A discarded frame, or a beat count different from expected, increments frames_err.
  - Otherwise frames_ok increments.
  - Next state is DRAIN.
- DRAIN: one cycle with rready=0, then IDLE. This gives the slave's rx_clear one cycle to settle.
- Timeout: a counter clears on every state change and every handshake. When it reaches TIMEOUT_CYCLES-1:
  - arvalid, rready, m_valid and m_last are dropped.
  - frames_err increments.
  - The FSM goes to IDLE.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: every output is 0, including arvalid, rready, araddr, m_*, frame_*, counters and busy. The state is IDLE, and the edge detector treats rx_ready_int as previously high, so a level held through reset does not trigger.
- Latency from the rx_ready_int edge to arvalid: 2 cycles (1 cycle for edge registration, 1 for the state transition).
- The data path adds zero latency: m_data/m_valid are combinational from R.
- rready follows m_ready in the same cycle. The AXI slave is the storage; there is no local buffer.
- A handshake completes only when valid and ready are both high at a clock edge. araddr stays stable while arvalid=1.
- rst_n assertion mid-burst immediately returns all outputs to their reset values. The slave's partially read frame is not recovered.
- If frames_ok and frames_err are both eligible to increment in one cycle, only the error increments; a frame is never counted twice.

## Structure
- Shared package eth_pkg:
  - the state enum eth_rx_fetch_state_t;
  - the register address constants reused from the ethernet address map (`ETHERNET_RX_DATA, `ETHERNET_RX_DATA_COUNT, `ETHERNET_RX_PROTOCOL_TYPE);
  - ETH_MAX_FRAME_BYTES.
- One natural sub-module: eth_sat_counter (16-bit saturating counter with inc input), instantiated twice.

## Test plan
- rx_ready_int rises, slave returns count=64, proto=16'h0800, 16 data beats with rlast on the 16th, m_ready=1 → 16 words in order, m_last on word 16, frames_ok=1, frame_len=64, frame_proto=16'h0800.
- Same frame with count=61 and m_ready toggling every other cycle → 16 words, no word duplicated or lost, rready mirrors m_ready, frames_ok=1.
- count=2000 (> 1522) → data burst read with m_valid never high, frames_err=1, frames_ok unchanged, FSM back in IDLE.
- count=0 → no AR to RX_DATA, frames_err=1, busy low 3 cycles after R_CNT.
- Slave never asserts arready with TIMEOUT_CYCLES=16 → arvalid drops after 16 cycles, frames_err=1, FSM in IDLE. A new rx_ready_int edge then fetches normally.
- rst_n pulsed low during beat 5 of 16 → all outputs 0 at once. With rx_ready_int held high through and after reset, no fetch starts until a new rising edge.
